// File: rtl/button_move_pulser.sv
// Debounces two bouncy push-buttons and turns each press into one move pulse,
// followed by auto-repeat pulses while held; pressing both locks out all pulses.
module button_move_pulser #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REPEAT_DELAY    = 5000000,
  parameter int REPEAT_PERIOD   = 1250000,
  parameter int CNT_W           = 24
) (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic i_btn_Left_raw,
  input  logic i_btn_Right_raw,
  output logic o_btn_Left,
  output logic o_btn_Right,
  output logic o_Left_held,
  output logic o_Right_held
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_DELAY = 2'd1,
    REPEAT     = 2'd2,
    LOCKED     = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RP_LAST  = CNT_W'(REPEAT_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Index 0 is the left button, index 1 the right button.
  logic [1:0]       raw;
  logic [1:0]       sync1_q, sync2_q;
  logic [1:0]       level_q, level_d;
  logic [1:0]       pulse_q, pulse_d;
  logic [CNT_W-1:0] db_cnt_q  [2];
  logic [CNT_W-1:0] db_cnt_d  [2];
  logic [CNT_W-1:0] rep_cnt_q [2];
  logic [CNT_W-1:0] rep_cnt_d [2];
  state_t           state_q   [2];
  state_t           state_d   [2];
  logic             both_held;

  assign raw       = {i_btn_Right_raw, i_btn_Left_raw};
  assign both_held = &level_q;

  // Debounce: the level flips only after DEBOUNCE_CYCLES consecutive mismatches.
  always_comb begin
    level_d = level_q;
    for (int b = 0; b < 2; b++) begin
      db_cnt_d[b] = '0;
      if (sync2_q[b] != level_q[b]) begin
        if (db_cnt_q[b] == DB_LAST) begin
          level_d[b] = ~level_q[b];
        end else begin
          db_cnt_d[b] = db_cnt_q[b] + CNT_ONE;
        end
      end
    end
  end

  // Release wins over lock, lock wins over any pulse that would be due.
  always_comb begin
    pulse_d = '0;
    for (int b = 0; b < 2; b++) begin
      state_d[b]   = state_q[b];
      rep_cnt_d[b] = rep_cnt_q[b] + CNT_ONE;
      if (!level_q[b]) begin
        state_d[b]   = IDLE;
        rep_cnt_d[b] = '0;
      end else if (both_held) begin
        state_d[b]   = LOCKED;
        rep_cnt_d[b] = '0;
      end else begin
        case (state_q[b])
          IDLE: begin
            state_d[b]   = WAIT_DELAY;
            pulse_d[b]   = 1'b1;
            rep_cnt_d[b] = '0;
          end
          WAIT_DELAY: begin
            if (rep_cnt_q[b] == RD_LAST) begin
              state_d[b]   = REPEAT;
              pulse_d[b]   = 1'b1;
              rep_cnt_d[b] = '0;
            end
          end
          REPEAT: begin
            if (rep_cnt_q[b] == RP_LAST) begin
              pulse_d[b]   = 1'b1;
              rep_cnt_d[b] = '0;
            end
          end
          LOCKED: begin
            rep_cnt_d[b] = '0;
          end
          default: begin
            state_d[b]   = IDLE;
            rep_cnt_d[b] = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      level_q <= '0;
      pulse_q <= '0;
      for (int b = 0; b < 2; b++) begin
        db_cnt_q[b]  <= '0;
        rep_cnt_q[b] <= '0;
        state_q[b]   <= IDLE;
      end
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      level_q <= level_d;
      pulse_q <= pulse_d;
      for (int b = 0; b < 2; b++) begin
        db_cnt_q[b]  <= db_cnt_d[b];
        rep_cnt_q[b] <= rep_cnt_d[b];
        state_q[b]   <= state_d[b];
      end
    end
  end

  assign o_btn_Left   = pulse_q[0];
  assign o_btn_Right  = pulse_q[1];
  assign o_Left_held  = level_q[0];
  assign o_Right_held = level_q[1];

endmodule
